// File: rtl/fir_pkg.sv
// Shared defaults, accumulator sizing and output scaling/saturation for the parallel FIR.
// FIR_LANE selects lane j of a packed multi-lane bus; usable on either side of an assignment.
`ifndef FIR_PKG_MACROS
`define FIR_PKG_MACROS
`define FIR_LANE(bus, j, w) bus[(j)*(w) +: (w)]
`endif

package fir_pkg;

    localparam int FIR_DW    = 8;
    localparam int FIR_CW    = 8;
    localparam int FIR_NTAPS = 9;
    localparam int FIR_L     = 3;
    localparam int FIR_AW    = 4;

    typedef struct packed {
        logic signed [63:0] val;
        logic               ovf;
    } sat_t;

    function automatic int fir_accw(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    // Arithmetic (floor) right shift, then clip to a dw-bit signed range.
    function automatic sat_t sat_trunc(input logic signed [63:0] acc, input int sh, input int dw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               r;
        s  = acc >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end else begin
            r.val = s;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_lane.sv
// One output lane: registered tap products, then registered sum with scaling and saturation.
module fir_lane
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int CW    = FIR_CW,
    parameter int NTAPS = FIR_NTAPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_s1_i,
    input  logic                 en_s2_i,
    input  logic signed [DW-1:0] win_i  [NTAPS],
    input  logic signed [CW-1:0] coef_i [NTAPS],
    output logic signed [DW-1:0] dout_o,
    output logic                 ovf_o
);

    localparam int PW   = DW + CW;
    localparam int ACCW = fir_accw(DW, CW, NTAPS);

    logic signed [PW-1:0]   prod_q [NTAPS];
    logic signed [PW-1:0]   prod_d [NTAPS];
    logic signed [ACCW-1:0] acc;
    sat_t                   sat_r;
    logic [63-DW:0]         sat_unused_hi;
    logic signed [DW-1:0]   dout_q, dout_d;
    logic                   ovf_q, ovf_d;

    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            prod_d[i] = en_s1_i ? PW'(win_i[i]) * PW'(coef_i[i]) : prod_q[i];
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAPS; i++) begin
            acc = acc + ACCW'(prod_q[i]);
        end
        sat_r = sat_trunc(64'(acc), CW - 1, DW);
        dout_d = en_s2_i ? sat_r.val[DW-1:0] : dout_q;
        ovf_d  = en_s2_i ? sat_r.ovf : ovf_q;
    end

    // Clipped value always fits DW bits; upper bits are sign copies.
    assign sat_unused_hi = sat_r.val[63:DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NTAPS; i++) prod_q[i] <= prod_d[i];
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout_o = dout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/fir_par_cfg.sv
// L-parallel direct-form FIR: shared delay line, shadow/active coefficient banks,
// two-stage valid pipe, and one fir_lane per output lane.
module fir_par_cfg
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int CW    = FIR_CW,
    parameter int NTAPS = FIR_NTAPS,
    parameter int L     = FIR_L,
    parameter int AW    = FIR_AW
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            VIN,
    input  logic [L*DW-1:0] DIN,
    input  logic            COEF_WE,
    input  logic [AW-1:0]   COEF_ADDR,
    input  logic [CW-1:0]   COEF_DATA,
    input  logic            COEF_COMMIT,
    output logic [L*DW-1:0] DOUT,
    output logic            VOUT,
    output logic            OVF
);

    logic signed [DW-1:0] hist_q   [NTAPS-1];
    logic signed [DW-1:0] hist_d   [NTAPS-1];
    logic signed [DW-1:0] seq      [L+NTAPS-1];
    logic signed [CW-1:0] shadow_q [NTAPS];
    logic signed [CW-1:0] shadow_d [NTAPS];
    logic signed [CW-1:0] active_q [NTAPS];
    logic signed [CW-1:0] active_d [NTAPS];
    logic                 v1_q, v2_q;
    logic [L-1:0]         lane_ovf;

    // seq is newest-first: current block (lane L-1 first), then stored history.
    always_comb begin
        for (int j = 0; j < L; j++) seq[L-1-j] = `FIR_LANE(DIN, j, DW);
        for (int p = 0; p < NTAPS - 1; p++) seq[L+p] = hist_q[p];
        for (int p = 0; p < NTAPS - 1; p++) hist_d[p] = VIN ? seq[p] : hist_q[p];
    end

    // Out-of-range addresses match no tap and are dropped.
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (COEF_WE && (COEF_ADDR == AW'(i))) shadow_d[i] = COEF_DATA;
            active_d[i] = COEF_COMMIT ? shadow_q[i] : active_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int p = 0; p < NTAPS - 1; p++) hist_q[p] <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            v1_q <= VIN;
            v2_q <= v1_q;
            for (int p = 0; p < NTAPS - 1; p++) hist_q[p] <= hist_d[p];
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lane
        logic signed [DW-1:0] win [NTAPS];
        logic signed [DW-1:0] lane_dout;

        always_comb begin
            for (int i = 0; i < NTAPS; i++) win[i] = seq[L-1-j+i];
        end

        fir_lane #(
            .DW    (DW),
            .CW    (CW),
            .NTAPS (NTAPS)
        ) u_lane (
            .clk     (clk),
            .rst     (RST),
            .en_s1_i (VIN),
            .en_s2_i (v1_q),
            .win_i   (win),
            .coef_i  (active_q),
            .dout_o  (lane_dout),
            .ovf_o   (lane_ovf[j])
        );

        assign `FIR_LANE(DOUT, j, DW) = lane_dout;
    end

    assign VOUT = v2_q;
    assign OVF  = |lane_ovf;

endmodule

// File: tb/tb_fir_par_cfg.sv
// Directed bench for fir_par_cfg: reset, impulse, saturation, commit timing,
// address bounds and gapped-valid streaming against a direct convolution model.
module tb_fir_par_cfg;

    localparam int DW = 8;
    localparam int NT = 9;

    logic          clk;
    logic          RST;
    logic          VIN;
    logic [23:0]   DIN;
    logic          COEF_WE;
    logic [3:0]    COEF_ADDR;
    logic [7:0]    COEF_DATA;
    logic          COEF_COMMIT;
    logic [23:0]   DOUT;
    logic          VOUT;
    logic          OVF;

    int checks   = 0;
    int failures = 0;

    int h_m  [NT];
    int xs   [64];
    int ey   [16][3];
    int eo   [16];
    int pat  [8];
    int last_y [3];
    int last_o;

    fir_par_cfg dut (
        .clk         (clk),
        .RST         (RST),
        .VIN         (VIN),
        .DIN         (DIN),
        .COEF_WE     (COEF_WE),
        .COEF_ADDR   (COEF_ADDR),
        .COEF_DATA   (COEF_DATA),
        .COEF_COMMIT (COEF_COMMIT),
        .DOUT        (DOUT),
        .VOUT        (VOUT),
        .OVF         (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lane(input int j);
        return int'($signed(DOUT[j*DW +: DW]));
    endfunction

    task automatic chk_out(input string tag, input int v, input int y0, input int y1,
                           input int y2, input int o);
        chk({tag, ".vout"}, int'(VOUT), v);
        chk({tag, ".y0"}, lane(0), y0);
        chk({tag, ".y1"}, lane(1), y1);
        chk({tag, ".y2"}, lane(2), y2);
        chk({tag, ".ovf"}, int'(OVF), o);
    endtask

    task automatic drive(input int v, input int a, input int b, input int c);
        VIN = v[0];
        DIN = {8'(c), 8'(b), 8'(a)};
    endtask

    task automatic send(input int a, input int b, input int c);
        drive(1, a, b, c);
        tick();
    endtask

    task automatic idle();
        VIN = 1'b0;
        tick();
    endtask

    task automatic wr(input int a, input int d);
        COEF_WE   = 1'b1;
        COEF_ADDR = 4'(a);
        COEF_DATA = 8'(d);
        tick();
        COEF_WE   = 1'b0;
    endtask

    task automatic commit();
        COEF_COMMIT = 1'b1;
        tick();
        COEF_COMMIT = 1'b0;
    endtask

    function automatic int ref_raw(input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < NT; i++) if (n - i >= 0) acc += h_m[i] * xs[n - i];
        return acc >>> 7;
    endfunction

    initial begin
        int nx;
        int nb;
        int rb;
        int v;
        int pv;
        int r;
        int d [3];

        RST = 1'b1; VIN = 1'b1; DIN = 24'h7F7F7F;
        COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0; COEF_COMMIT = 1'b0;

        // 1: reset holds everything at zero even with VIN asserted
        tick();
        chk_out("rst1", 0, 0, 0, 0, 0);
        tick();
        chk_out("rst2", 0, 0, 0, 0, 0);
        RST = 1'b0;
        send(0, 0, 0);
        chk("post_rst.edge1.vout", int'(VOUT), 0);
        idle();
        chk_out("post_rst.edge2", 1, 0, 0, 0, 0);

        // 2: impulse through h[i] = 8*(i+1)
        for (int i = 0; i < NT; i++) wr(i, 8 * (i + 1));
        commit();
        send(127, 0, 0);
        send(0, 0, 0);
        chk_out("imp.b0", 1, 7, 15, 23, 0);
        send(0, 0, 0);
        chk_out("imp.b1", 1, 31, 39, 47, 0);
        send(0, 0, 0);
        chk_out("imp.b2", 1, 55, 63, 71, 0);
        idle();
        chk_out("imp.b3", 1, 0, 0, 0, 0);
        idle();
        chk_out("imp.gap_hold", 0, 0, 0, 0, 0);

        // 3: saturation with all taps 127
        for (int i = 0; i < NT; i++) wr(i, 127);
        commit();
        send(127, 127, 127);
        send(127, 127, 127);
        chk_out("sat.first", 1, 126, 127, 127, 1);
        send(127, 127, 127);
        send(127, 127, 127);
        chk_out("sat.pos", 1, 127, 127, 127, 1);
        send(-128, -128, -128);
        send(-128, -128, -128);
        send(-128, -128, -128);
        send(-128, -128, -128);
        idle();
        chk_out("sat.neg", 1, -128, -128, -128, 1);
        idle();
        chk_out("sat.hold", 0, -128, -128, -128, 1);

        // 4: commit timing, only h[0] nonzero so history does not matter
        wr(0, 32);
        for (int i = 1; i < NT; i++) wr(i, 0);
        commit();
        wr(0, 64);
        send(40, 80, -41);
        idle();
        chk_out("cmt.uncommitted", 1, 10, 20, -11, 0);
        COEF_COMMIT = 1'b1;
        send(40, 80, -41);
        COEF_COMMIT = 1'b0;
        idle();
        chk_out("cmt.same_edge_old", 1, 10, 20, -11, 0);
        send(40, 80, -41);
        idle();
        chk_out("cmt.next_new", 1, 20, 40, -21, 0);
        COEF_WE = 1'b1; COEF_ADDR = 4'd0; COEF_DATA = 8'd16; COEF_COMMIT = 1'b1;
        tick();
        COEF_WE = 1'b0; COEF_COMMIT = 1'b0;
        send(40, 80, -41);
        idle();
        chk_out("cmt.we_and_commit", 1, 20, 40, -21, 0);
        commit();
        send(40, 80, -41);
        idle();
        chk_out("cmt.shadow_landed", 1, 5, 10, -6, 0);

        // 6: writes beyond the last tap are dropped
        for (int a = NT; a < 16; a++) wr(a, 127);
        commit();
        send(40, 80, -41);
        idle();
        chk_out("addr.bounds", 1, 5, 10, -6, 0);

        // 5: gapped valid against direct convolution over the accepted stream
        h_m = '{3, -5, 7, 11, -13, 17, 19, -23, 29};
        for (int i = 0; i < NT; i++) wr(i, h_m[i]);
        commit();
        send(0, 0, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        idle();
        idle();
        pat = '{1, 0, 0, 1, 1, 0, 1, 1};
        nx = 0; nb = 0; rb = 0; last_o = 0;
        for (int i = 0; i < 3; i++) last_y[i] = 0;
        for (int c = 0; c < 10; c++) begin
            v = (c < 8) ? pat[c] : 0;
            for (int j = 0; j < 3; j++) d[j] = int'($urandom_range(0, 255)) - 128;
            drive(v, d[0], d[1], d[2]);
            if (v != 0) begin
                eo[nb] = 0;
                for (int j = 0; j < 3; j++) begin
                    xs[nx + j] = d[j];
                    r = ref_raw(nx + j);
                    if (r > 127) begin r = 127; eo[nb] = 1; end
                    if (r < -128) begin r = -128; eo[nb] = 1; end
                    ey[nb][j] = r;
                end
                nx += 3;
                nb++;
            end
            tick();
            if (c >= 1) begin
                pv = (c - 1 < 8) ? pat[c - 1] : 0;
                if (pv != 0) begin
                    for (int j = 0; j < 3; j++) last_y[j] = ey[rb][j];
                    last_o = eo[rb];
                    rb++;
                end
                chk_out($sformatf("gap.c%0d", c), pv, last_y[0], last_y[1], last_y[2], last_o);
            end
        end
        VIN = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
